// File: rtl/alarm_clock_core.sv
// Time-of-week counter (sec/min/hrs/day), alarm registers and the alarm
// state machine (IDLE / RING / SNOOZE) with snooze and buzzer auto-off.
// All time and alarm advances are qualified by the one-per-second tick.
module alarm_clock_core #(
    parameter int NS       = 60,
    parameter int NM       = 60,
    parameter int NH       = 24,
    parameter int ND       = 7,
    parameter int WD       = 5,
    parameter int CW       = 7,
    parameter int SNOOZE_S = 540,
    parameter int RING_S   = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    timeset,
    input  logic                    alarmset,
    input  logic                    minadv,
    input  logic                    hrsadv,
    input  logic                    dayadv,
    input  logic                    alarmon,
    input  logic                    wkday_only,
    input  logic                    snooze,
    output logic [CW-1:0]           tsec,
    output logic [CW-1:0]           tmin,
    output logic [CW-1:0]           thrs,
    output logic [$clog2(ND)-1:0]   tday,
    output logic [CW-1:0]           amin,
    output logic [CW-1:0]           ahrs,
    output logic                    d_max,
    output logic                    buzz,
    output logic [1:0]              alm_state
);

    localparam int DW = $clog2(ND);

    localparam logic [CW-1:0] S_LAST     = CW'(NS - 1);
    localparam logic [CW-1:0] M_LAST     = CW'(NM - 1);
    localparam logic [CW-1:0] H_LAST     = CW'(NH - 1);
    localparam logic [DW-1:0] D_LAST     = DW'(ND - 1);
    localparam logic [DW:0]   WD_LIM     = (DW+1)'(WD);
    localparam logic [15:0]   RING_LAST  = 16'(RING_S - 1);
    localparam logic [15:0]   SNZ_INIT   = 16'(SNOOZE_S);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] ring_cnt, ring_nxt;
    logic [15:0] snz_cnt, snz_nxt;

    logic set_tick, alm_tick;
    logic s_wrap, m_wrap, h_wrap;
    logic match, match_q, match_rise;
    logic snooze_q, snz_edge;
    logic force_idle;

    // Wrapping increment shared by all time/alarm fields.
    function automatic logic [CW-1:0] inc_mod(input logic [CW-1:0] v,
                                              input logic [CW-1:0] last);
        return (v == last) ? '0 : v + 1'b1;
    endfunction

    assign set_tick = tick & timeset;
    assign alm_tick = tick & alarmset & ~timeset;
    assign s_wrap   = tick & ~timeset & (tsec == S_LAST);
    assign m_wrap   = s_wrap & (tmin == M_LAST);
    assign h_wrap   = m_wrap & (thrs == H_LAST);

    // Match is taken from registered time/alarm values only.
    assign match = alarmon & ~timeset & ~alarmset & (tsec == '0) &
                   (tmin == amin) & (thrs == ahrs) &
                   (~wkday_only | ({1'b0, tday} < WD_LIM));

    // Ringing starts on the rising edge of match so that an auto-off in the
    // same matching second cannot immediately re-trigger the alarm.
    assign match_rise = match & ~match_q;
    assign snz_edge   = snooze & ~snooze_q;
    assign force_idle = ~alarmon | timeset | alarmset;

    // Time-of-week counters; seconds freeze (not clear) while time is set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tsec  <= '0;
            tmin  <= '0;
            thrs  <= '0;
            tday  <= '0;
            d_max <= 1'b0;
        end else begin
            if (tick && !timeset)
                tsec <= inc_mod(tsec, S_LAST);
            if (s_wrap || (set_tick && minadv))
                tmin <= inc_mod(tmin, M_LAST);
            if (m_wrap || (set_tick && hrsadv))
                thrs <= inc_mod(thrs, H_LAST);
            if (h_wrap || (set_tick && dayadv))
                tday <= (tday == D_LAST) ? '0 : tday + 1'b1;
            d_max <= h_wrap & (tday == D_LAST);
        end
    end

    // Alarm setting registers; no carry from minutes into hours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            amin <= '0;
            ahrs <= '0;
        end else if (alm_tick) begin
            if (minadv) amin <= inc_mod(amin, M_LAST);
            if (hrsadv) ahrs <= inc_mod(ahrs, H_LAST);
        end
    end

    // Edge-detect history for the match and snooze button.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_q  <= 1'b0;
            snooze_q <= 1'b0;
        end else begin
            match_q  <= match;
            snooze_q <= snooze;
        end
    end

    // Alarm FSM state register with its counters and the registered buzzer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            buzz     <= 1'b0;
        end else begin
            state    <= state_nxt;
            ring_cnt <= ring_nxt;
            snz_cnt  <= snz_nxt;
            buzz     <= (state_nxt == ST_RING);
        end
    end

    // Alarm FSM next-state; leaving any alarm mode has top priority.
    always_comb begin
        state_nxt = state;
        ring_nxt  = ring_cnt;
        snz_nxt   = snz_cnt;
        if (force_idle) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match_rise) begin
                        state_nxt = ST_RING;
                        ring_nxt  = '0;
                    end
                end
                ST_RING: begin
                    if (snz_edge) begin
                        state_nxt = ST_SNOOZE;
                        snz_nxt   = SNZ_INIT;
                    end else if (tick) begin
                        if (ring_cnt == RING_LAST)
                            state_nxt = ST_IDLE;
                        else
                            ring_nxt = ring_cnt + 1'b1;
                    end
                end
                ST_SNOOZE: begin
                    if (tick) begin
                        if (snz_cnt == 16'd1) begin
                            state_nxt = ST_RING;
                            ring_nxt  = '0;
                        end else begin
                            snz_nxt = snz_cnt - 1'b1;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // State is exported directly for the display and for debug.
    always_comb begin
        alm_state = state;
    end

endmodule

// File: tb/tb_alarm_clock_core.sv
// Bench for alarm_clock_core: directed scenarios plus random stimulus,
// checked every cycle against a time-of-week reference model.
module tb_alarm_clock_core;

    localparam int NS       = 60;
    localparam int NM       = 60;
    localparam int NH       = 24;
    localparam int ND       = 7;
    localparam int WD       = 5;
    localparam int CW       = 7;
    localparam int SNOOZE_S = 3;
    localparam int RING_S   = 4;
    localparam int DW       = $clog2(ND);
    localparam int HOUR_S   = NS * NM;
    localparam int DAY_S    = HOUR_S * NH;
    localparam int WEEK_S   = DAY_S * ND;
    localparam int EW       = 5 * CW + DW + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic tick = 1'b0, timeset = 1'b0, alarmset = 1'b0;
    logic minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0;
    logic alarmon = 1'b0, wkday_only = 1'b0, snooze = 1'b0;

    logic [CW-1:0] tsec, tmin, thrs, amin, ahrs;
    logic [DW-1:0] tday;
    logic          d_max, buzz;
    logic [1:0]    alm_state;

    alarm_clock_core #(
        .NS(NS), .NM(NM), .NH(NH), .ND(ND), .WD(WD), .CW(CW),
        .SNOOZE_S(SNOOZE_S), .RING_S(RING_S)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .timeset(timeset),
        .alarmset(alarmset), .minadv(minadv), .hrsadv(hrsadv),
        .dayadv(dayadv), .alarmon(alarmon), .wkday_only(wkday_only),
        .snooze(snooze), .tsec(tsec), .tmin(tmin), .thrs(thrs),
        .tday(tday), .amin(amin), .ahrs(ahrs), .d_max(d_max),
        .buzz(buzz), .alm_state(alm_state)
    );

    logic [EW-1:0] act;
    assign act = {tsec, tmin, thrs, tday, amin, ahrs, d_max, buzz, alm_state};

    // ---------------- reference model ----------------
    // Time kept as seconds since start of week; alarm FSM as countdowns.
    int tow;
    int al_min, al_hr;
    int m_state;          // 0 idle, 1 ringing, 2 snoozing
    int ring_left, snz_left;
    bit snz_prev, match_prev, m_dmax;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        tow = 0; al_min = 0; al_hr = 0; m_state = 0;
        ring_left = 0; snz_left = 0;
        snz_prev = 0; match_prev = 0; m_dmax = 0;
    endtask

    function automatic logic [EW-1:0] expected();
        logic [CW-1:0] s, m, h, am, ah;
        logic [DW-1:0] d;
        s  = CW'(tow % NS);
        m  = CW'((tow / NS) % NM);
        h  = CW'((tow / HOUR_S) % NH);
        d  = DW'(tow / DAY_S);
        am = CW'(al_min);
        ah = CW'(al_hr);
        return {s, m, h, d, am, ah, m_dmax, (m_state == 1), 2'(m_state)};
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int sec, mn, hr, dy;
        bit match, sedge;
        sec = tow % NS;
        mn  = (tow / NS) % NM;
        hr  = (tow / HOUR_S) % NH;
        dy  = tow / DAY_S;
        match = alarmon && !timeset && !alarmset && sec == 0 &&
                mn == al_min && hr == al_hr && (!wkday_only || dy < WD);
        sedge = snooze && !snz_prev;

        if (!alarmon || timeset || alarmset) begin
            m_state = 0;
        end else if (m_state == 0) begin
            if (match && !match_prev) begin m_state = 1; ring_left = RING_S; end
        end else if (m_state == 1) begin
            if (sedge) begin
                m_state = 2; snz_left = SNOOZE_S;
            end else if (tick) begin
                ring_left--;
                if (ring_left == 0) m_state = 0;
            end
        end else begin
            if (tick) begin
                snz_left--;
                if (snz_left == 0) begin m_state = 1; ring_left = RING_S; end
            end
        end

        m_dmax = 0;
        if (tick) begin
            if (!timeset) begin
                m_dmax = (tow == WEEK_S - 1);
                tow = (tow + 1) % WEEK_S;
            end else begin
                if (minadv) mn = (mn + 1) % NM;
                if (hrsadv) hr = (hr + 1) % NH;
                if (dayadv) dy = (dy + 1) % ND;
                tow = dy * DAY_S + hr * HOUR_S + mn * NS + sec;
            end
            if (alarmset && !timeset) begin
                if (minadv) al_min = (al_min + 1) % NM;
                if (hrsadv) al_hr  = (al_hr + 1) % NH;
            end
        end
        snz_prev   = snooze;
        match_prev = match;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit t);
        tick = t;
        model_edge();
        @(posedge clk);
        exp_q.push_back(expected());
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s, input int d);
        int nm, nh, nd, n, mx;
        timeset = 0; alarmset = 0; minadv = 0; hrsadv = 0; dayadv = 0;
        n = (s - (tow % NS) + NS) % NS;
        repeat (n) cycle(1);
        timeset = 1;
        nm = (m - (tow / NS) % NM + NM) % NM;
        nh = (h - (tow / HOUR_S) % NH + NH) % NH;
        nd = (d - tow / DAY_S + ND) % ND;
        mx = (nm > nh) ? nm : nh;
        mx = (nd > mx) ? nd : mx;
        for (int i = 0; i < mx; i++) begin
            minadv = (i < nm); hrsadv = (i < nh); dayadv = (i < nd);
            cycle(1);
        end
        minadv = 0; hrsadv = 0; dayadv = 0; timeset = 0;
        cycle(0);
    endtask

    task automatic set_alarm(input int h, input int m);
        int nm, nh, mx;
        timeset = 0; alarmset = 1;
        nm = (m - al_min + NM) % NM;
        nh = (h - al_hr + NH) % NH;
        mx = (nm > nh) ? nm : nh;
        for (int i = 0; i < mx; i++) begin
            minadv = (i < nm); hrsadv = (i < nh);
            cycle(1);
        end
        minadv = 0; hrsadv = 0; alarmset = 0;
        cycle(0);
    endtask

    task automatic tick_run(input int n);
        repeat (n) begin cycle(1); cycle(0); end
    endtask

    // Reset asserted between clock edges; outputs must clear at once.
    task automatic async_reset();
        @(negedge clk);
        #1;
        rst = 0;
        model_reset();
        #1;
        total++;
        if (act !== expected()) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", act, expected());
        end
        @(posedge clk);
        exp_q.push_back(expected());
        #1;
        rst = 1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t got=%h exp=%h", $time, act, e);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst = 0;
        @(posedge clk);
        exp_q.push_back(expected());
        #1;
        rst = 1;
        repeat (3) cycle(0);

        // Full carry 23:59:58 day 6 -> 00:00:00 day 0 with one-cycle d_max.
        set_time(23, 59, 58, 6);
        tick_run(3);

        // Manual minute advance does not carry and seconds hold.
        set_time(10, 59, 30, 2);
        timeset = 1; minadv = 1;
        repeat (3) cycle(1);
        minadv = 0; timeset = 0;
        cycle(0);

        // Ring and auto-off, no re-ring in the same second.
        set_alarm(7, 0);
        set_time(6, 59, 58, 1);
        alarmon = 1;
        tick_run(10);

        // Snooze, held button, re-press, alarmon drop while snoozing.
        alarmon = 0;
        set_time(6, 59, 58, 2);
        alarmon = 1;
        tick_run(3);
        snooze = 1;
        repeat (5) cycle(1);
        snooze = 0; cycle(0);
        snooze = 1; cycle(0);
        cycle(1);
        alarmon = 0; cycle(0);
        snooze = 0; cycle(0);

        // Weekday-only: day 5 silent, day 4 rings; reset lands mid-ring.
        wkday_only = 1;
        set_time(6, 59, 59, 5);
        alarmon = 1;
        tick_run(4);
        alarmon = 0;
        set_time(6, 59, 59, 4);
        alarmon = 1;
        tick_run(2);
        cycle(0);
        async_reset();
        tick_run(6);

        // Random phase around an upcoming alarm.
        alarmon = 0; wkday_only = 0;
        set_alarm(12, 1);
        set_time(12, 0, 50, 3);
        alarmon = 1;
        for (int i = 0; i < 800; i++) begin
            timeset    = ($urandom_range(0, 31) == 0);
            alarmset   = ($urandom_range(0, 31) == 0);
            minadv     = $urandom_range(0, 1);
            hrsadv     = $urandom_range(0, 1);
            dayadv     = $urandom_range(0, 1);
            alarmon    = ($urandom_range(0, 15) != 0);
            snooze     = ($urandom_range(0, 3) == 0) ? ~snooze : snooze;
            if ($urandom_range(0, 63) == 0) wkday_only = ~wkday_only;
            if (i % 200 == 100) begin
                timeset = 0; alarmset = 0; alarmon = 0; wkday_only = 0;
                set_alarm((tow / HOUR_S) % NH, ((tow / NS) % NM + 1) % NM);
                alarmon = 1;
            end
            cycle($urandom_range(0, 1));
        end
        timeset = 0; alarmset = 0;
        cycle(0);

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_clock_core.md
Name: alarm_clock_core

Overview:
Parametrised time-keeping and alarm core for the Lab 2 digital clock. It replaces the separate sec/min/hrs counters, alarm registers and comparator with one block. It adds a day-of-week counter, a weekday-only alarm mode, snooze, and auto-off of the buzzer. The core runs on a single system clock with a one-cycle-per-second tick enable, and its outputs feed the existing lcd_int display drivers.

Parameters:
NS, 60, seconds modulus
NM, 60, minutes modulus
NH, 24, hours modulus
ND, 7, days-per-week modulus (ND >= WD)
WD, 5, days 0..WD-1 are weekdays
CW, 7, width of sec/min/hrs outputs (NS, NM, NH <= 2**CW)
SNOOZE_S, 540, snooze length in ticks (1..65535)
RING_S, 60, ticks of buzzing before auto-off (1..65535)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
tick  in  1  one-cycle pulse per second; all time/alarm advances are qualified by it
timeset  in  1  time-set mode: seconds hold; minadv/hrsadv/dayadv advance time
alarmset  in  1  alarm-set mode: minadv/hrsadv advance the alarm registers
minadv  in  1  advance minutes at 1 per tick while held
hrsadv  in  1  advance hours at 1 per tick while held
dayadv  in  1  advance day at 1 per tick while held (timeset only)
alarmon  in  1  alarm enable
wkday_only  in  1  1 = alarm fires only when tday < WD
snooze  in  1  snooze button, level; its rising edge is used
tsec, tmin, thrs  out  CW  current time
tday  out  $clog2(ND)  current day, 0..ND-1
amin, ahrs  out  CW  alarm setting
d_max  out  1  one-cycle pulse when the day wraps ND-1 -> 0 by carry
buzz  out  1  alarm sounding
alm_state  out  2  0 IDLE, 1 RING, 2 SNOOZE

Behaviour:
- Reset (rst=0, async): all counters, alarm regs, snooze/ring counters and snooze_q go to 0. State = IDLE, buzz = 0, d_max = 0.
- Mode priority: timeset > alarmset. If both are high, the alarm regs hold.
- Seconds:
  - On tick with timeset=0: tsec = (tsec==NS-1) ? 0 : tsec+1.
  - s_wrap = tick & !timeset & tsec==NS-1.
  - With timeset=1, tsec holds its value (it is not cleared).
- Minutes:
  - Advance (mod NM) on s_wrap, or on tick & timeset & minadv.
  - m_wrap = s_wrap & tmin==NM-1. Manual advance never carries into hours.
- Hours:
  - Advance (mod NH) on m_wrap, or on tick & timeset & hrsadv.
  - h_wrap = m_wrap & thrs==NH-1.
- Day:
  - Advance (mod ND) on h_wrap, or on tick & timeset & dayadv.
  - d_max = h_wrap & tday==ND-1, registered, high for exactly one cycle.
- Alarm regs:
  - On tick & alarmset & !timeset: amin advances mod NM if minadv; ahrs advances mod NH if hrsadv.
  - No carry between amin and ahrs. Both may advance on the same tick.
- match = alarmon & !timeset & !alarmset & tsec==0 & tmin==amin & thrs==ahrs & (!wkday_only | tday<WD). It is computed from registered values.
- snz_edge = snooze & !snooze_q, where snooze_q is registered every clk.
- FSM transitions, evaluated every clk in the priority order listed:
  - Any state: alarmon=0, timeset=1 or alarmset=1 -> IDLE.
  - IDLE: match -> RING, ring_cnt=0.
  - RING, on snz_edge -> SNOOZE, snz_cnt=SNOOZE_S.
  - RING, otherwise on tick -> ring_cnt+1. When ring_cnt==RING_S-1 on a tick -> IDLE (auto-off).
  - SNOOZE: on tick, snz_cnt-1. When snz_cnt==1 on a tick -> RING, ring_cnt=0. snz_edge is ignored in this state.
- IDLE re-entry after auto-off in the same second: match is still true, so the FSM would re-ring. To prevent this, the FSM may enter RING from IDLE only on a cycle where tick is high, or on the first cycle after match rises. The implementation registers match and uses its rising edge as the IDLE -> RING trigger.
- buzz = (state==RING), registered. Latency: buzz rises 1 clk after the tick that makes tsec 0 at the matching time.
- Reset release with alarmon=1 and alarm 00:00 gives an immediate match rise, so buzz rises 1 clk after rst deasserts. This is intended.
- Counter arithmetic is unsigned. No state ever holds a value >= its modulus.

Test Plan:
- Time carry: preload 23:59:58, day 6 via timeset/adv, then release. Two ticks give 00:00:00, day 0, and d_max high for exactly 1 clk.
- Set behaviour: timeset=1, minadv=1 for 3 ticks from 10:59:30. Result 10:02:30, hours unchanged, tsec held at 30.
- Alarm ring + auto-off: RING_S=4, alarm 07:00, time 06:59:58. buzz rises 1 clk after the 07:00:00 tick, falls after 4 ticks, and does not re-ring.
- Snooze: SNOOZE_S=3. Snooze edge while RING -> buzz 0, alm_state=2. 3 ticks later buzz=1. Holding snooze high yields no second edge.
- Weekday mode: wkday_only=1, tday=5, alarm matches -> no buzz. Same alarm with tday=4 -> buzz.
- Async reset mid-RING: rst=0 between clk edges gives buzz=0 and all outputs 0 immediately. Priority: alarmon drop during SNOOZE -> IDLE next clk.
